// File: rtl/medidor_frec_multi.sv
// Multi-channel frequency meter: counts synchronised rising edges of N_CHAN async inputs over a gate of resol clocks.
// Optional continuous re-arming mode is enabled by defining MEDIDOR_FREC_CONT_EN.
module medidor_frec_multi #(
  parameter int N_CHAN      = 4,
  parameter int OUT_WIDTH   = 32,
  parameter int RESOL_WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [RESOL_WIDTH-1:0]      resol,
  input  logic [N_CHAN-1:0]           sig_in,
  input  logic                        ack,
  output logic                        busy,
  output logic                        valid,
  output logic [N_CHAN*OUT_WIDTH-1:0] data_out,
  output logic [N_CHAN-1:0]           overflow,
  output logic [1:0]                  fsm_state
);

  // Handshake: valid high means data_out/overflow hold a complete result; ack in DONE retires it.
  typedef enum logic [1:0] {IDLE = 2'd0, MEASURE = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0][N_CHAN-1:0] sync_q;
  logic [N_CHAN-1:0]                  prev_q;
  logic [N_CHAN-1:0]                  edge_det;
  logic [N_CHAN-1:0][OUT_WIDTH-1:0]   cnt_q;
  logic [N_CHAN-1:0]                  ovf_q;
  logic [RESOL_WIDTH-1:0]             gate_q;
  logic                               start_acc, start_meas, start_zero, win_end;

  assign edge_det   = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign start_acc  = start && (state == IDLE || state == DONE);
  assign start_meas = start_acc && (resol != '0);
  assign start_zero = start_acc && (resol == '0);
  assign win_end    = (state == MEASURE) && (gate_q == '0);

`ifdef MEDIDOR_FREC_CONT_EN
  logic [RESOL_WIDTH-1:0] resol_q;
  logic                   pulse_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      resol_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      if (start_meas) resol_q <= resol;
      pulse_q <= win_end;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_meas)      state_nxt = MEASURE;
        else if (start_zero) state_nxt = DONE;
      end
      MEASURE: begin
`ifdef MEDIDOR_FREC_CONT_EN
        state_nxt = MEASURE;
`else
        if (win_end) state_nxt = DONE;
`endif
      end
      DONE: begin
        if (start_meas)      state_nxt = MEASURE;
        else if (start_zero) state_nxt = DONE;
`ifndef MEDIDOR_FREC_CONT_EN
        else if (ack)        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == MEASURE);
`ifdef MEDIDOR_FREC_CONT_EN
    valid     = (state == DONE) || pulse_q;
`else
    valid     = (state == DONE);
`endif
    fsm_state = state;
  end

  // Gate runs resol counting cycles, then one extra cycle publishes the counters.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_q   <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= '0;
      gate_q   <= '0;
      data_out <= '0;
      overflow <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];

      if (start_meas) begin
        cnt_q  <= '0;
        ovf_q  <= '0;
        gate_q <= resol;
      end else if (state == MEASURE) begin
        if (gate_q != '0) begin
          gate_q <= gate_q - RESOL_WIDTH'(1);
          for (int i = 0; i < N_CHAN; i++) begin
            if (edge_det[i]) begin
              if (cnt_q[i] == '1) ovf_q[i] <= 1'b1;
              else                cnt_q[i] <= cnt_q[i] + OUT_WIDTH'(1);
            end
          end
        end
`ifdef MEDIDOR_FREC_CONT_EN
        // Reload cycle: its edge opens the next window, so the gate runs one cycle shorter.
        else begin
          gate_q <= resol_q - RESOL_WIDTH'(1);
          ovf_q  <= '0;
          for (int i = 0; i < N_CHAN; i++) cnt_q[i] <= OUT_WIDTH'(edge_det[i]);
        end
`endif
      end

      if (start_zero) begin
        data_out <= '0;
        overflow <= '0;
      end else if (win_end) begin
        data_out <= cnt_q;
        overflow <= ovf_q;
      end
    end
  end

endmodule

// File: tb/tb_medidor_frec_multi.sv
// Bench for medidor_frec_multi: deterministic square waves, a rise-counting reference model and a result scoreboard.
module tb_medidor_frec_multi;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int RW = 32;
  localparam int EW = N*W + N;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          ack = 1'b0;
  logic [RW-1:0] resol = '0;
  logic [N-1:0]  sig_in = '0;
  logic          busy, valid;
  logic [N*W-1:0] data_out;
  logic [N-1:0]  overflow;
  logic [1:0]    fsm_state;

  medidor_frec_multi #(.N_CHAN(N), .OUT_WIDTH(W), .RESOL_WIDTH(RW), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .resol(resol), .sig_in(sig_in),
    .ack(ack), .busy(busy), .valid(valid), .data_out(data_out), .overflow(overflow),
    .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0, bad = 0, results = 0, want = 0, sum0 = 0;
  int per[N], ph[N];
  bit en[N];
  logic [EW-1:0]  exp_q[$];
  int             exp_cyc_q[$];
  logic [N*W-1:0] last_data = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit wave(int i, int n);
    if (!en[i] || per[i] < 2) return 1'b0;
    return ((n + ph[i]) % per[i]) < (per[i] / 2);
  endfunction

  // A rise driven after edge n is counted at edge n+3; counted edges are k+1..k+r.
  function automatic logic [EW-1:0] model(int k, int r);
    logic [N*W-1:0] d = '0;
    logic [N-1:0]   o = '0;
    if (r != 0) begin
      for (int i = 0; i < N; i++) begin
        int c = 0;
        for (int n = k - 2; n <= k + r - 3; n++)
          if (wave(i, n) && !wave(i, n - 1)) c++;
        if (c > 255) begin
          o[i] = 1'b1;
          c = 255;
        end
        d[i*W +: W] = W'(c);
      end
    end
    return {o, d};
  endfunction

  // stimulus generator: sig_in changes only on falling edges
  initial forever begin
    @(negedge clock);
    for (int i = 0; i < N; i++) sig_in[i] = wave(i, cyc);
  end

  // scoreboard: compare each new result against the queued expectation
  initial begin
    bit vp = 1'b0;
    logic [EW-1:0] e;
    int ec;
    forever begin
      @(negedge clock);
      if (valid && !vp) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(valid), 64'(0));
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("data", 64'(data_out), 64'(e[N*W-1:0]));
          check("overflow", 64'(overflow), 64'(e[EW-1:N*W]));
          check("latency", 64'(cyc), 64'(ec));
          sum0 += int'(data_out[W-1:0]);
        end
        results++;
      end
      vp = valid;
    end
  end

  // driver tasks
  task automatic set_wave(input int p0, input int p1, input int p2, input int p3);
    per = '{p0, p1, p2, p3};
    for (int i = 0; i < N; i++) begin
      en[i] = (per[i] >= 2);
      ph[i] = en[i] ? int'($urandom_range(0, per[i] - 1)) : 0;
    end
    repeat (6) @(negedge clock);
  endtask

  task automatic do_start(input int r, input bit with_ack, input bit expect_res);
    logic [EW-1:0] e;
    start = 1'b1;
    ack   = with_ack;
    resol = RW'(r);
    if (expect_res) begin
      e = model(cyc + 1, r);
      exp_q.push_back(e);
      exp_cyc_q.push_back((r == 0) ? cyc + 1 : cyc + r + 2);
      last_data = e[N*W-1:0];
    end
    @(negedge clock);
    start = 1'b0;
    ack   = 1'b0;
  endtask

  task automatic wait_results(input int target, input int budget);
    int n = 0;
    while (results < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (results < target) check("timeout", 64'(results), 64'(target));
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    check("ack_valid", 64'(valid), 64'(0));
    check("ack_busy", 64'(busy), 64'(0));
    check("ack_hold", 64'(data_out), 64'(last_data));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_valid"}, 64'(valid), 64'(0));
    check({tag, "_data"}, 64'(data_out), 64'(0));
    check({tag, "_ovf"}, 64'(overflow), 64'(0));
    check({tag, "_state"}, 64'(fsm_state), 64'(0));
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_reset("reset");
    reset_n = 1'b1;

`ifdef MEDIDOR_FREC_CONT_EN
    begin
      int k;
      set_wave(10, 0, 0, 0);
      k = cyc + 1;
      do_start(100, 0, 0);
      for (int j = 0; j < 20; j++) begin
        exp_q.push_back(model(k + 100*j, 100));
        exp_cyc_q.push_back(k + 100*j + 101);
      end
      wait_results(20, 2300);
      check("cont_total", 64'(sum0), 64'(200));
      check("cont_busy", 64'(busy), 64'(1));
    end
`else
    // basic counts, with an ignored start mid-window
    set_wave(10, 20, 4, 7);
    do_start(1000, 0, 1);
    check("busy_start", 64'(busy), 64'(1));
    repeat (300) @(negedge clock);
    start = 1'b1;
    resol = RW'(5);
    @(negedge clock);
    start = 1'b0;
    want++; wait_results(want, 1100);
    do_ack();

    // saturation on fast channels, slow channel unaffected
    set_wave(2, 50, 3, 0);
    do_start(1000, 0, 1);
    want++; wait_results(want, 1100);

    // start and ack together in DONE: the start wins
    set_wave(10, 20, 4, 7);
    do_start(200, 1, 1);
    check("restart_busy", 64'(busy), 64'(1));
    check("restart_valid", 64'(valid), 64'(0));
    want++; wait_results(want, 300);
    do_ack();

    // zero gate
    do_start(0, 0, 1);
    want++; wait_results(want, 10);
    do_ack();

    // one-cycle gate with the fastest countable input
    for (int j = 0; j < 4; j++) begin
      set_wave(2, 2, 2, 2);
      do_start(1, 0, 1);
      want++; wait_results(want, 10);
      do_ack();
    end

    // random gates and periods, restarting straight from DONE
    for (int j = 0; j < 6; j++) begin
      set_wave($urandom_range(2, 13), $urandom_range(2, 13), $urandom_range(2, 13), $urandom_range(2, 13));
      do_start($urandom_range(1, 80), 1'($urandom_range(0, 1)), 1);
      want++; wait_results(want, 120);
    end
    do_ack();

    // reset in the middle of a window
    set_wave(10, 20, 4, 7);
    do_start(1000, 0, 0);
    repeat (499) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check_reset("midreset");
    reset_n = 1'b1;
    set_wave(10, 20, 4, 7);
    do_start(300, 0, 1);
    want++; wait_results(want, 400);
    do_ack();
`endif

    repeat (5) @(negedge clock);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
